thor2022_rfsrc_recover: RTL and testbench

//  Branch-miss recovery sequencer for the register-source (rename) table.
//  On a miss, clears every register source to "none", then walks the reorder buffer

---
 rtl/thor2022_rfsrc_recover.sv | 78 +++++++
 tb/tb_thor2022_rfsrc_recover.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/thor2022_rfsrc_recover.sv
// thor2022_rfsrc_recover: branch-miss sequencer that clears and rebuilds the register-source table from the reorder buffer
module thor2022_rfsrc_recover #(
  parameter int REB_ENTRIES = 8,
  parameter int IDW = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_i,
  input  logic [IDW-1:0]           head_i,
  input  logic [IDW:0]             cnt_i,
  input  logic [REB_ENTRIES-1:0]   ent_v_i,
  input  logic [REB_ENTRIES-1:0]   ent_wr_i,
  input  logic [6*REB_ENTRIES-1:0] ent_rt_i,
  input  logic [6*REB_ENTRIES-1:0] ent_rt2_i,
  output logic                     busy_o,
  output logic                     stall_o,
  output logic                     clr_o,
  output logic                     wr0_o,
  output logic [5:0]               wr0_reg_o,
  output logic                     wr1_o,
  output logic [5:0]               wr1_reg_o,
  output logic [5:0]               wr_src_o,
  output logic                     done_o
);
  typedef enum logic [1:0] {IDLE, CLEAR, WALK, DONE} state_t;
  localparam logic [IDW:0] MAX_CNT = (IDW+1)'(REB_ENTRIES);
  localparam logic [IDW-1:0] LAST = IDW'(REB_ENTRIES - 1);
  state_t r_state, w_state_nx;
  logic [IDW-1:0] r_ptr, w_ptr_nx;
  logic [IDW:0] r_rem, w_rem_nx;
  logic [5:0] w_rt [REB_ENTRIES];
  logic [5:0] w_rt2 [REB_ENTRIES];
  logic [5:0] w_rt_cur, w_rt2_cur;
  logic w_walk, w_live;
  for (genvar i = 0; i < REB_ENTRIES; i++) begin : g_ent
    assign w_rt[i]  = ent_rt_i[6*i +: 6];
    assign w_rt2[i] = ent_rt2_i[6*i +: 6];
  end
  assign w_walk    = r_state == WALK;
  assign w_rt_cur  = w_rt[r_ptr];
  assign w_rt2_cur = w_rt2[r_ptr];
  assign w_live    = w_walk & ent_v_i[r_ptr] & ent_wr_i[r_ptr];
  assign busy_o    = r_state != IDLE;
  assign stall_o   = miss_i | busy_o;
  assign clr_o     = r_state == CLEAR;
  assign done_o    = r_state == DONE;
  assign wr0_o     = w_live & (w_rt_cur != 6'd0);
  assign wr1_o     = w_live & (w_rt2_cur != 6'd0) & (w_rt2_cur != w_rt_cur);
  assign wr0_reg_o = w_walk ? w_rt_cur : 6'd0;
  assign wr1_reg_o = w_walk ? w_rt2_cur : 6'd0;
  assign wr_src_o  = w_walk ? {{(6-IDW){1'b0}}, r_ptr} : 6'd0;
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_rem_nx   = r_rem;
    if (miss_i) begin
      w_state_nx = CLEAR;
      w_ptr_nx   = head_i;
      w_rem_nx   = cnt_i > MAX_CNT ? MAX_CNT : cnt_i;
    end else begin
      w_state_nx = r_state == CLEAR ? (r_rem != '0 ? WALK : DONE) :
                   w_walk           ? (r_rem > 1 ? WALK : DONE) : IDLE;
      w_ptr_nx   = w_walk ? (r_ptr == LAST ? '0 : r_ptr + 1'b1) : r_ptr;
      w_rem_nx   = w_walk ? r_rem - 1'b1 : r_rem;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_rem   <= w_rem_nx;
    end
  end
endmodule

// File: tb/tb_thor2022_rfsrc_recover.sv
// tb_thor2022_rfsrc_recover: directed checks of the rename-table recovery sequencer with a source-table model
module tb_thor2022_rfsrc_recover;
  logic clk = 1'b0;
  logic rst, miss_i;
  logic [2:0] head_i;
  logic [3:0] cnt_i;
  logic [7:0] ent_v_i, ent_wr_i;
  logic [47:0] ent_rt_i, ent_rt2_i;
  logic busy_o, stall_o, clr_o, wr0_o, wr1_o, done_o;
  logic [5:0] wr0_reg_o, wr1_reg_o, wr_src_o;
  logic [5:0] tbl [64];
  int n_chk = 0;
  int n_err = 0;
  thor2022_rfsrc_recover dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .head_i(head_i), .cnt_i(cnt_i),
    .ent_v_i(ent_v_i), .ent_wr_i(ent_wr_i), .ent_rt_i(ent_rt_i), .ent_rt2_i(ent_rt2_i),
    .busy_o(busy_o), .stall_o(stall_o), .clr_o(clr_o), .wr0_o(wr0_o), .wr0_reg_o(wr0_reg_o),
    .wr1_o(wr1_o), .wr1_reg_o(wr1_reg_o), .wr_src_o(wr_src_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst && clr_o) begin
      for (int k = 0; k < 64; k++) tbl[k] <= 6'd31;
    end else if (rst) begin
      if (wr0_o) tbl[wr0_reg_o] <= wr_src_o;
      if (wr1_o) tbl[wr1_reg_o] <= wr_src_o;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input string tag, input logic busy, input logic clr, input logic done);
    chk({tag, " busy"}, busy_o, busy);
    chk({tag, " clr"}, clr_o, clr);
    chk({tag, " done"}, done_o, done);
  endtask
  task automatic walk(input string tag, input logic w0, input int r0, input logic w1, input int r1, input int src);
    ctl(tag, 1'b1, 1'b0, 1'b0);
    chk({tag, " wr0"}, wr0_o, w0);
    chk({tag, " wr1"}, wr1_o, w1);
    if (w0) chk({tag, " reg0"}, wr0_reg_o, r0);
    if (w1) chk({tag, " reg1"}, wr1_reg_o, r1);
    chk({tag, " src"}, wr_src_o, src);
  endtask
  task automatic start(input int head, input int cnt);
    head_i = 3'(head);
    cnt_i  = 4'(cnt);
    miss_i = 1'b1;
    #1;
    chk("miss stall", stall_o, 1'b1);
    tick();
    miss_i = 1'b0;
    ctl("clear", 1'b1, 1'b1, 1'b0);
    chk("clear wr0", wr0_o, 1'b0);
    chk("clear wr1", wr1_o, 1'b0);
  endtask
  task automatic set_ent(input int n, input logic v, input logic w, input int rt, input int rt2);
    ent_v_i[n]  = v;
    ent_wr_i[n] = w;
    ent_rt_i[6*n +: 6]  = 6'(rt);
    ent_rt2_i[6*n +: 6] = 6'(rt2);
  endtask
  initial begin
    rst = 1'b0; miss_i = 1'b1; head_i = 3'd5; cnt_i = 4'd8;
    ent_v_i = '0; ent_wr_i = '0; ent_rt_i = '0; ent_rt2_i = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      ctl("reset", 1'b0, 1'b0, 1'b0);
      chk("reset wr0", wr0_o, 1'b0);
      chk("reset wr1", wr1_o, 1'b0);
      chk("reset stall", stall_o, 1'b1);
    end
    rst = 1'b1; miss_i = 1'b0;
    tick();
    ctl("idle", 1'b0, 1'b0, 1'b0);
    chk("idle stall", stall_o, 1'b0);
    start(5, 0);
    tick();
    ctl("empty done", 1'b1, 1'b0, 1'b1);
    chk("empty wr0", wr0_o, 1'b0);
    tick();
    ctl("empty idle", 1'b0, 1'b0, 1'b0);
    set_ent(6, 1, 1, 3, 0); set_ent(7, 1, 1, 4, 0);
    set_ent(0, 1, 1, 5, 0); set_ent(1, 1, 1, 6, 0);
    start(6, 4);
    tick(); walk("wrap e6", 1, 3, 0, 0, 6);
    tick(); walk("wrap e7", 1, 4, 0, 0, 7);
    tick(); walk("wrap e0", 1, 5, 0, 0, 0);
    tick(); walk("wrap e1", 1, 6, 0, 0, 1);
    tick(); ctl("wrap done", 1'b1, 1'b0, 1'b1);
    tick(); ctl("wrap idle", 1'b0, 1'b0, 1'b0);
    chk("tbl r6", tbl[6], 1);
    set_ent(0, 1, 1, 9, 9); set_ent(1, 0, 1, 10, 0); set_ent(2, 1, 1, 9, 0);
    start(0, 3);
    tick(); walk("ovr e0", 1, 9, 0, 0, 0);
    tick(); walk("ovr e1", 0, 0, 0, 0, 1);
    tick(); walk("ovr e2", 1, 9, 0, 0, 2);
    tick(); ctl("ovr done", 1'b1, 1'b0, 1'b1);
    tick();
    chk("tbl r9", tbl[9], 2);
    chk("tbl r10", tbl[10], 31);
    chk("tbl r3", tbl[3], 31);
    for (int n = 0; n < 8; n++) set_ent(n, 1, 1, 10 + n, 20 + n);
    start(0, 8);
    for (int n = 0; n < 3; n++) begin
      tick(); walk("rst1 walk", 1, 10 + n, 1, 20 + n, n);
    end
    head_i = 3'd2; cnt_i = 4'd1; miss_i = 1'b1;
    tick(); miss_i = 1'b0;
    ctl("restart clr", 1'b1, 1'b1, 1'b0);
    tick(); walk("restart e2", 1, 12, 1, 22, 2);
    tick(); ctl("restart done", 1'b1, 1'b0, 1'b1);
    tick(); ctl("restart idle", 1'b0, 1'b0, 1'b0);
    start(5, 12);
    for (int n = 0; n < 8; n++) begin
      tick(); walk("clamp walk", 1, 10 + (5 + n) % 8, 1, 20 + (5 + n) % 8, (5 + n) % 8);
    end
    tick(); ctl("clamp done", 1'b1, 1'b0, 1'b1);
    tick();
    start(0, 8);
    tick(); tick();
    rst = 1'b0;
    tick(); rst = 1'b1;
    ctl("abort", 1'b0, 1'b0, 1'b0);
    chk("abort wr0", wr0_o, 1'b0);
    chk("abort wr1", wr1_o, 1'b0);
    chk("abort src", wr_src_o, 0);
    start(3, 2);
    tick(); walk("clean e3", 1, 13, 1, 23, 3);
    tick(); walk("clean e4", 1, 14, 1, 24, 4);
    tick(); ctl("clean done", 1'b1, 1'b0, 1'b1);
    tick(); ctl("clean idle", 1'b0, 1'b0, 1'b0);
    chk("tbl r14", tbl[14], 4);
    chk("tbl r12", tbl[12], 31);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
